// File: rtl/decode_pipe_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode pipe stage and execute.
// The master side is the surrounding pipeline; the slave side is the stage itself.
interface decode_pipe_stage_if #(
  parameter int INST_W     = 16,
  parameter int OP_W       = 4,
  parameter int REG_W      = 4,
  parameter int DATA_W     = 16,
  parameter int HIST_DEPTH = 3
);
  localparam int DIST_W = $clog2(HIST_DEPTH + 1);

  logic              i_valid;
  logic              o_ready;
  logic [INST_W-1:0] i_inst;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [OP_W-1:0]   o_opcode;
  logic [REG_W-1:0]  o_srcadd_1;
  logic [REG_W-1:0]  o_srcadd_2;
  logic [REG_W-1:0]  o_destadd;
  logic              o_is_imm;
  logic [DATA_W-1:0] o_imm;
  logic              o_hazard;
  logic [DIST_W-1:0] o_hazard_dist;

  modport master (
    output i_valid, i_inst, i_flush, i_ready,
    input  o_ready, o_valid, o_opcode, o_srcadd_1, o_srcadd_2, o_destadd,
    input  o_is_imm, o_imm, o_hazard, o_hazard_dist
  );

  modport slave (
    input  i_valid, i_inst, i_flush, i_ready,
    output o_ready, o_valid, o_opcode, o_srcadd_1, o_srcadd_2, o_destadd,
    output o_is_imm, o_imm, o_hazard, o_hazard_dist
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Registered instruction decode stage: splits fields, sign-extends the immediate format,
// and flags read-after-write hazards against a short history of accepted destinations.
module decode_pipe_stage #(
  parameter int                INST_W      = 16,
  parameter int                OP_W        = 4,
  parameter int                REG_W       = 4,
  parameter int                DATA_W      = 16,
  parameter logic [OP_W-1:0]   IMM_OP      = 4'hA,
  parameter int                HIST_DEPTH  = 3,
  parameter bit                ZERO_REG_EN = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  decode_pipe_stage_if.slave bus
);
  localparam int DIST_W = $clog2(HIST_DEPTH + 1);

  generate
    if (INST_W != OP_W + 3 * REG_W) begin : g_bad_inst_w
      $error("decode_pipe_stage: INST_W must equal OP_W + 3*REG_W");
    end
    if (DATA_W < 2 * REG_W) begin : g_bad_data_w
      $error("decode_pipe_stage: DATA_W must be at least 2*REG_W");
    end
    if (HIST_DEPTH < 1 || HIST_DEPTH > 8) begin : g_bad_depth
      $error("decode_pipe_stage: HIST_DEPTH must be in 1..8");
    end
  endgenerate

  function automatic logic src_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] addr);
    logic zero_src;
    zero_src = ZERO_REG_EN && (src == {REG_W{1'b0}});
    return (src == addr) && !zero_src;
  endfunction

  logic [OP_W-1:0]   opcode_s;
  logic [REG_W-1:0]  field1_s;
  logic [REG_W-1:0]  field2_s;
  logic [REG_W-1:0]  field3_s;
  logic              is_imm_s;
  logic [DATA_W-1:0] imm_s;
  logic              accept_s;
  logic              hit_s;
  logic [DIST_W-1:0] dist_s;

  logic              valid_q,  valid_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]  src1_q,   src1_d;
  logic [REG_W-1:0]  src2_q,   src2_d;
  logic [REG_W-1:0]  dest_q,   dest_d;
  logic              is_imm_q, is_imm_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic              hazard_q, hazard_d;
  logic [DIST_W-1:0] dist_q,   dist_d;
  logic              hist_vld_q  [HIST_DEPTH];
  logic              hist_vld_d  [HIST_DEPTH];
  logic [REG_W-1:0]  hist_addr_q [HIST_DEPTH];
  logic [REG_W-1:0]  hist_addr_d [HIST_DEPTH];

  assign opcode_s = bus.i_inst[INST_W-1 -: OP_W];
  assign field1_s = bus.i_inst[INST_W-OP_W-1 -: REG_W];
  assign field2_s = bus.i_inst[INST_W-OP_W-REG_W-1 -: REG_W];
  assign field3_s = bus.i_inst[REG_W-1:0];
  assign is_imm_s = (opcode_s == IMM_OP);
  assign imm_s    = DATA_W'($signed(bus.i_inst[2*REG_W-1:0]));

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept_s    = bus.i_valid && bus.o_ready && !bus.i_flush;

  // Nearest matching history entry; walking oldest-to-newest lets the youngest match win.
  always_comb begin
    hit_s  = 1'b0;
    dist_s = {DIST_W{1'b0}};
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (!is_imm_s && hist_vld_q[i] &&
          (src_match(field1_s, hist_addr_q[i]) || src_match(field2_s, hist_addr_q[i]))) begin
        hit_s  = 1'b1;
        dist_s = DIST_W'(i + 1);
      end else begin
        hit_s  = hit_s;
        dist_s = dist_s;
      end
    end
  end

  // Next-state selection: flush beats accept; a consumed output with no new accept goes invalid.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dest_d   = dest_q;
    is_imm_d = is_imm_q;
    imm_d    = imm_q;
    hazard_d = hazard_q;
    dist_d   = dist_q;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hist_vld_d[i]  = hist_vld_q[i];
      hist_addr_d[i] = hist_addr_q[i];
    end

    if (bus.i_flush) begin
      valid_d = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_vld_d[i] = 1'b0;
      end
    end else if (accept_s) begin
      valid_d  = 1'b1;
      opcode_d = opcode_s;
      is_imm_d = is_imm_s;
      hazard_d = hit_s;
      dist_d   = dist_s;
      if (is_imm_s) begin
        src1_d = {REG_W{1'b0}};
        src2_d = {REG_W{1'b0}};
        dest_d = field1_s;
        imm_d  = imm_s;
      end else begin
        src1_d = field1_s;
        src2_d = field2_s;
        dest_d = field3_s;
        imm_d  = {DATA_W{1'b0}};
      end
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_vld_d[i]  = hist_vld_q[i-1];
        hist_addr_d[i] = hist_addr_q[i-1];
      end
      hist_vld_d[0]  = 1'b1;
      hist_addr_d[0] = dest_d;
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= {OP_W{1'b0}};
      src1_q   <= {REG_W{1'b0}};
      src2_q   <= {REG_W{1'b0}};
      dest_q   <= {REG_W{1'b0}};
      is_imm_q <= 1'b0;
      imm_q    <= {DATA_W{1'b0}};
      hazard_q <= 1'b0;
      dist_q   <= {DIST_W{1'b0}};
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_vld_q[i]  <= 1'b0;
        hist_addr_q[i] <= {REG_W{1'b0}};
      end
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dest_q   <= dest_d;
      is_imm_q <= is_imm_d;
      imm_q    <= imm_d;
      hazard_q <= hazard_d;
      dist_q   <= dist_d;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_vld_q[i]  <= hist_vld_d[i];
        hist_addr_q[i] <= hist_addr_d[i];
      end
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_opcode      = opcode_q;
  assign bus.o_srcadd_1    = src1_q;
  assign bus.o_srcadd_2    = src2_q;
  assign bus.o_destadd     = dest_q;
  assign bus.o_is_imm      = is_imm_q;
  assign bus.o_imm         = imm_q;
  assign bus.o_hazard      = hazard_q;
  assign bus.o_hazard_dist = dist_q;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed plus randomized bench for decode_pipe_stage, checked against a queue-based
// reference model of decode, hazard history and the pipeline handshake.
module tb_decode_pipe_stage;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  decode_pipe_stage_if bus ();
  decode_pipe_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic        m_known = 1'b0;
  logic        m_valid;
  logic [3:0]  m_op, m_s1, m_s2, m_d;
  logic        m_isimm;
  logic [15:0] m_imm;
  logic        m_hz;
  logic [1:0]  m_dist;
  int          hist[$];
  logic [15:0] acc_q[$];
  int          n_acc = 0;
  int          n_cons = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [15:0] inst, output logic [3:0] op,
                                 output logic [3:0] s1, output logic [3:0] s2,
                                 output logic [3:0] d, output logic ii, output logic [15:0] imm);
    int w, low;
    w   = int'(inst);
    op  = 4'(w / 4096);
    low = w % 256;
    if (op == 4'hA) begin
      ii = 1'b1; d = 4'((w / 256) % 16); s1 = 4'd0; s2 = 4'd0;
      imm = 16'((low >= 128) ? (low - 256) : low);
    end else begin
      ii = 1'b0; s1 = 4'((w / 256) % 16); s2 = 4'((w / 16) % 16); d = 4'(w % 16);
      imm = 16'd0;
    end
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({bus.o_valid, bus.o_opcode, bus.o_srcadd_1, bus.o_srcadd_2, bus.o_destadd,
                bus.o_is_imm, bus.o_imm, bus.o_hazard, bus.o_hazard_dist});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_valid, m_op, m_s1, m_s2, m_d, m_isimm, m_imm, m_hz, m_dist});
  endfunction

  task automatic model_update(input logic v, input logic [15:0] inst, input logic fl,
                              input logic rd, input logic rs);
    logic accept;
    accept = rs && v && (!m_valid || rd) && !fl;
    if (!rs) begin
      m_valid = 1'b0; m_op = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0; m_d = 4'd0;
      m_isimm = 1'b0; m_imm = 16'd0; m_hz = 1'b0; m_dist = 2'd0;
      hist.delete(); acc_q.delete(); m_known = 1'b1;
    end else if (fl) begin
      m_valid = 1'b0; hist.delete(); acc_q.delete();
    end else if (accept) begin
      decode(inst, m_op, m_s1, m_s2, m_d, m_isimm, m_imm);
      m_hz = 1'b0; m_dist = 2'd0;
      if (!m_isimm) begin
        for (int k = 0; k < hist.size(); k++) begin
          if (!m_hz && ((m_s1 != 4'd0 && int'(m_s1) == hist[k]) ||
                        (m_s2 != 4'd0 && int'(m_s2) == hist[k]))) begin
            m_hz = 1'b1; m_dist = 2'(k + 1);
          end
        end
      end
      hist.push_front(int'(m_d));
      if (hist.size() > 3) void'(hist.pop_back());
      acc_q.push_back(inst);
      n_acc++;
      m_valid = 1'b1;
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  // one clock: drive, check ready and in-order delivery, step model, check registered outputs
  task automatic cyc(input logic v, input logic [15:0] inst, input logic fl,
                     input logic rd, input logic rs);
    logic [3:0]  op, s1, s2, d;
    logic        ii;
    logic [15:0] imm, old;
    rst_n = rs; bus.i_valid = v; bus.i_inst = inst; bus.i_flush = fl; bus.i_ready = rd;
    #1;
    if (m_known) chk("o_ready", 64'(bus.o_ready), 64'(!m_valid || rd));
    if (m_known && rs && !fl && bus.o_valid && rd) begin
      n_cons++;
      if (acc_q.size() == 0) begin
        chk("order_empty", 64'(acc_q.size()), 64'd1);
      end else begin
        old = acc_q.pop_front();
        decode(old, op, s1, s2, d, ii, imm);
        chk("order", 64'({bus.o_opcode, bus.o_srcadd_1, bus.o_srcadd_2, bus.o_destadd, bus.o_imm}),
            64'({op, s1, s2, d, imm}));
      end
    end
    model_update(v, inst, fl, rd, rs);
    @(posedge clk);
    #1;
    chk("outputs", dut_vec(), model_vec());
  endtask

  logic [15:0] r;

  initial begin
    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_inst = 16'd0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_ready", 64'(bus.o_ready), 64'd1);
    chk("reset_fields", dut_vec(), 64'd0);

    // basic decode and hazard distances
    cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    chk("basic", 64'({bus.o_valid, bus.o_opcode, bus.o_srcadd_1, bus.o_srcadd_2, bus.o_destadd,
                      bus.o_is_imm, bus.o_hazard}), 64'({1'b1, 16'h1234, 1'b0, 1'b0}));
    cyc(1'b1, 16'h2415, 1'b0, 1'b1, 1'b1);
    chk("haz_dist1", 64'({bus.o_hazard, bus.o_hazard_dist}), 64'({1'b1, 2'd1}));
    cyc(1'b1, 16'h3406, 1'b0, 1'b1, 1'b1);
    chk("haz_dist2", 64'({bus.o_hazard, bus.o_hazard_dist}), 64'({1'b1, 2'd2}));
    cyc(1'b1, 16'h3006, 1'b0, 1'b1, 1'b1);
    chk("zero_reg", 64'({bus.o_hazard, bus.o_hazard_dist}), 64'd0);

    // immediate format
    cyc(1'b1, 16'hA3F5, 1'b0, 1'b1, 1'b1);
    chk("imm_fields", 64'({bus.o_opcode, bus.o_destadd, bus.o_srcadd_1, bus.o_srcadd_2,
                           bus.o_is_imm, bus.o_imm, bus.o_hazard}),
        64'({4'hA, 4'h3, 4'h0, 4'h0, 1'b1, 16'hFFF5, 1'b0}));
    cyc(1'b1, 16'h1300, 1'b0, 1'b1, 1'b1);
    chk("imm_dest_haz", 64'({bus.o_hazard, bus.o_hazard_dist}), 64'({1'b1, 2'd1}));

    // backpressure: output holds 16'h1300 while downstream stalls
    n_acc = 0; n_cons = 0;
    cyc(1'b1, 16'h4567, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h4567, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h4567, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h4567, 1'b0, 1'b0, 1'b1);
    chk("bp_hold", 64'({bus.o_valid, bus.o_opcode, bus.o_srcadd_1, bus.o_destadd}),
        64'({1'b1, 4'h1, 4'h3, 4'h0}));
    chk("bp_ready", 64'(bus.o_ready), 64'd0);
    cyc(1'b1, 16'h4567, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h5678, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h6789, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("bp_count", 64'(n_cons), 64'd4);
    chk("bp_accepts", 64'(n_acc), 64'd3);

    // flush with valid output and full history
    cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h1111, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h1222, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h2415, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", 64'(bus.o_valid), 64'd0);
    cyc(1'b1, 16'h1444, 1'b0, 1'b1, 1'b1);
    chk("flush_hist", 64'({bus.o_valid, bus.o_hazard}), 64'({1'b1, 1'b0}));

    // randomized traffic with biased register addresses to provoke hazards
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      r[11:8] = 4'($urandom_range(0, 5));
      r[7:4]  = 4'($urandom_range(0, 5));
      r[3:0]  = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hA;
      cyc($urandom_range(0, 3) != 0, r, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0, 1'b1);
    end

    // reset in the middle of continuous traffic
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    chk("midrst_fields", dut_vec(), 64'd0);
    chk("midrst_ready", 64'(bus.o_ready), 64'd1);
    cyc(1'b1, 16'h1440, 1'b0, 1'b1, 1'b1);
    chk("midrst_hist", 64'({bus.o_valid, bus.o_hazard, bus.o_hazard_dist}), 64'({1'b1, 1'b0, 2'd0}));
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
